// File: rtl/return_addr_stack_pkg.sv
// Shared types and constants for the return address stack.
package ras_pkg;

  localparam int RAS_DEPTH_DEFAULT = 8;
  localparam int RAS_WIDTH_DEFAULT = 32;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef logic [RAS_WIDTH_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack with overflow/underflow/error pulses.
// Optional alignment check on pushes enabled by defining RAS_ALIGN_CHECK_EN.
module return_addr_stack
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT,
  parameter int WIDTH = RAS_WIDTH_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       PUSH,
  input  logic [WIDTH-1:0]           PUSH_ADDR,
  input  logic                       POP,
  output logic [WIDTH-1:0]           TOP_ADDR,
  output logic                       TOP_VALID,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  output logic                       ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp, tp_n, tp_inc, tp_dec, wr_idx;
  logic [CW-1:0]    cnt, cnt_n;
  logic             wr_en, ovf_n, udf_n, err_n;
  logic             push_ok, bad_push;

`ifdef RAS_ALIGN_CHECK_EN
  assign bad_push = PUSH && ((PUSH_ADDR[1:0] & ALIGN_MASK) != 2'b00);
`else
  assign bad_push = 1'b0;
`endif
  assign push_ok = PUSH && !bad_push;

  assign tp_inc = tp + 1'b1;
  assign tp_dec = tp - 1'b1;

  always_comb begin
    tp_n   = tp;
    cnt_n  = cnt;
    wr_en  = 1'b0;
    wr_idx = tp;
    ovf_n  = 1'b0;
    udf_n  = 1'b0;
    err_n  = 1'b0;
    if (FLUSH) begin
      tp_n  = '0;
      cnt_n = '0;
    end else begin
      err_n = bad_push;
      if (push_ok && POP && cnt != '0) begin
        // replace in place: a return immediately followed by a call
        wr_en = 1'b1;
      end else if (push_ok) begin
        tp_n   = tp_inc;
        wr_idx = tp_inc;
        wr_en  = 1'b1;
        if (cnt == FULL) ovf_n = 1'b1;
        else             cnt_n = cnt + 1'b1;
      end else if (POP) begin
        if (cnt != '0) begin
          tp_n  = tp_dec;
          cnt_n = cnt - 1'b1;
        end else begin
          udf_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tp        <= '0;
      cnt       <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      tp        <= tp_n;
      cnt       <= cnt_n;
      OVERFLOW  <= ovf_n;
      UNDERFLOW <= udf_n;
      ERR       <= err_n;
    end
  end

  // storage is not reset; writes are suppressed while reset is held
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) mem[wr_idx] <= PUSH_ADDR;
  end

  assign TOP_ADDR  = mem[tp];
  assign COUNT     = cnt;
  assign TOP_VALID = (cnt != '0);

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack (DEPTH=8, WIDTH=32).
module tb_return_addr_stack;
  import ras_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0, PUSH = 1'b0, POP = 1'b0;
  addr_t       PUSH_ADDR = '0;
  addr_t       TOP_ADDR;
  logic        TOP_VALID, OVERFLOW, UNDERFLOW, ERR;
  logic [3:0]  COUNT;

  int checks = 0;
  int errors = 0;
  int ovf_pulses;

  return_addr_stack #(.DEPTH(8), .WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .PUSH(PUSH), .PUSH_ADDR(PUSH_ADDR),
    .POP(POP), .TOP_ADDR(TOP_ADDR), .TOP_VALID(TOP_VALID), .COUNT(COUNT),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, sample #1 after the edge, return inputs to idle
  task automatic step(input logic push, input logic [31:0] addr, input logic pop, input logic flush);
    PUSH = push; PUSH_ADDR = addr; POP = pop; FLUSH = flush;
    @(posedge CLK); #1;
    PUSH = 1'b0; POP = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic o, input logic u, input logic e);
    check({tag, "_ovf"}, {63'd0, OVERFLOW}, {63'd0, o});
    check({tag, "_udf"}, {63'd0, UNDERFLOW}, {63'd0, u});
    check({tag, "_err"}, {63'd0, ERR}, {63'd0, e});
  endtask

  initial begin
    // reset state
    #3;
    check("rst_count", 64'(COUNT), 64'd0);
    check("rst_valid", 64'(TOP_VALID), 64'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // three pushes then one pop
    step(1, 32'h104, 0, 0);
    step(1, 32'h208, 0, 0);
    step(1, 32'h30C, 0, 0);
    check("push3_top", 64'(TOP_ADDR), 64'h30C);
    check("push3_count", 64'(COUNT), 64'd3);
    check("push3_valid", 64'(TOP_VALID), 64'd1);
    step(0, 0, 1, 0);
    check("pop_top", 64'(TOP_ADDR), 64'h208);
    check("pop_count", 64'(COUNT), 64'd2);

    // push+pop replaces top in place
    step(1, 32'h500, 1, 0);
    check("pp_top", 64'(TOP_ADDR), 64'h500);
    check("pp_count", 64'(COUNT), 64'd2);
    check_flags("pp", 1'b0, 1'b0, 1'b0);
    step(0, 0, 1, 0);
    check("pp_below", 64'(TOP_ADDR), 64'h104);
    check("pp_below_count", 64'(COUNT), 64'd1);

    // drain, then underflow
    step(0, 0, 1, 0);
    check("drain_count", 64'(COUNT), 64'd0);
    check("drain_valid", 64'(TOP_VALID), 64'd0);
    step(0, 0, 1, 0);
    check("udf_pulse", 64'(UNDERFLOW), 64'd1);
    check("udf_count", 64'(COUNT), 64'd0);
    step(0, 0, 0, 0);
    check("udf_clear", 64'(UNDERFLOW), 64'd0);
    step(1, 32'h40, 0, 0);
    check("after_udf_top", 64'(TOP_ADDR), 64'h40);
    check("after_udf_count", 64'(COUNT), 64'd1);

    // flush has priority over push
    step(1, 32'h44, 0, 0);
    step(1, 32'h48, 0, 0);
    check("pre_flush_count", 64'(COUNT), 64'd3);
    step(1, 32'h4C, 0, 1);
    check("flush_count", 64'(COUNT), 64'd0);
    check("flush_valid", 64'(TOP_VALID), 64'd0);
    check_flags("flush", 1'b0, 1'b0, 1'b0);

    // fill past depth: one overflow, oldest entry lost
    ovf_pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      step(1, 32'(4 * i), 0, 0);
      if (OVERFLOW) ovf_pulses++;
    end
    check("ovf_pulses", 64'(ovf_pulses), 64'd1);
    check("ovf_last", 64'(OVERFLOW), 64'd1);
    check("ovf_count", 64'(COUNT), 64'd8);
    check("ovf_top", 64'(TOP_ADDR), 64'h24);
    for (int i = 1; i <= 7; i++) step(0, 0, 1, 0);
    check("ovf_clear", 64'(OVERFLOW), 64'd0);
    check("pop7_top", 64'(TOP_ADDR), 64'h8);
    check("pop7_count", 64'(COUNT), 64'd1);
    step(0, 0, 1, 0);
    check("pop8_count", 64'(COUNT), 64'd0);
    check("pop8_valid", 64'(TOP_VALID), 64'd0);
    check("pop8_udf", 64'(UNDERFLOW), 64'd0);

    // push+pop on empty acts as push
    step(1, 32'h600, 1, 0);
    check("pp_empty_count", 64'(COUNT), 64'd1);
    check("pp_empty_top", 64'(TOP_ADDR), 64'h600);
    check("pp_empty_udf", 64'(UNDERFLOW), 64'd0);

    // misaligned push
    step(1, 32'h102, 0, 0);
`ifdef RAS_ALIGN_CHECK_EN
    check("mis_err", 64'(ERR), 64'd1);
    check("mis_count", 64'(COUNT), 64'd1);
    check("mis_top", 64'(TOP_ADDR), 64'h600);
    step(0, 0, 0, 0);
    check("mis_err_clear", 64'(ERR), 64'd0);
    step(1, 32'h203, 1, 0);
    check("mis_pop_count", 64'(COUNT), 64'd0);
    check("mis_pop_err", 64'(ERR), 64'd1);
`else
    check("mis_err", 64'(ERR), 64'd0);
    check("mis_count", 64'(COUNT), 64'd2);
    check("mis_top", 64'(TOP_ADDR), 64'h102);
`endif

    // asynchronous reset mid-sequence, with a push held across an edge
    step(1, 32'h700, 0, 0);
    step(1, 32'h704, 0, 0);
    @(negedge CLK); #2;
    PUSH = 1'b1; PUSH_ADDR = 32'h708; POP = 1'b0;
    RST = 1'b1;
    #1;
    check("arst_count", 64'(COUNT), 64'd0);
    check("arst_valid", 64'(TOP_VALID), 64'd0);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("arst_hold_count", 64'(COUNT), 64'd0);
    PUSH = 1'b0;
    @(negedge CLK); RST = 1'b0;
    step(1, 32'h800, 0, 0);
    check("post_rst_top", 64'(TOP_ADDR), 64'h800);
    check("post_rst_count", 64'(COUNT), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
